// File: rtl/mem_access_ctrl.sv
// Round-robin two-port access controller for the 8-row memory array.
// Build with MEM_ACCESS_CRC_EN defined to add the resp_crc output (CRC-8 of resp_rdata).
module mem_access_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ACCESS_CRC_EN
  ,
  output logic [7:0]        resp_crc
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int CW = 2;

  state_t            state, state_d;
  logic              last_grant, last_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              pick_b;
  logic              gnt_a_d, gnt_b_d;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              resp_valid_d, resp_id_d;
  logic [DATA_W-1:0] resp_rdata_d;
  logic              busy_d;
`ifdef MEM_ACCESS_CRC_EN
  logic [7:0]        crc_d;

  function automatic logic [7:0] crc8(input logic [DATA_W-1:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
`endif

  // last_grant doubles as the id of the access in flight
  always_comb begin
    state_d      = state;
    last_d       = last_grant;
    cnt_d        = cnt;
    pick_b       = req_b & (~req_a | ~last_grant);
    gnt_a_d      = 1'b0;
    gnt_b_d      = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id;
    resp_rdata_d = '0;
`ifdef MEM_ACCESS_CRC_EN
    crc_d        = 8'h00;
`endif
    unique case (state)
      IDLE: begin
        if (req_a | req_b) begin
          state_d     = ISSUE;
          last_d      = pick_b;
          gnt_a_d     = ~pick_b;
          gnt_b_d     = pick_b;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_b ? we_b : we_a;
          mem_addr_d  = pick_b ? addr_b : addr_a;
          mem_wdata_d = pick_b ? wdata_b : wdata_a;
        end
      end
      ISSUE: begin
        if (mem_we) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_id_d    = last_grant;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(MEM_LAT);
        end
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_id_d    = last_grant;
          resp_rdata_d = mem_rdata;
`ifdef MEM_ACCESS_CRC_EN
          crc_d        = crc8(mem_rdata);
`endif
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_rdata <= '0;
      busy       <= 1'b0;
`ifdef MEM_ACCESS_CRC_EN
      resp_crc   <= 8'h00;
`endif
    end else begin
      state      <= state_d;
      last_grant <= last_d;
      cnt        <= cnt_d;
      gnt_a      <= gnt_a_d;
      gnt_b      <= gnt_b_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      resp_valid <= resp_valid_d;
      resp_id    <= resp_id_d;
      resp_rdata <= resp_rdata_d;
      busy       <= busy_d;
`ifdef MEM_ACCESS_CRC_EN
      resp_crc   <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (MEM_LAT 1 and 3) against a
// transaction-level model and a latency-exact behavioural memory.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tgt;
  logic       req_a, we_a, req_b, we_b;
  logic [2:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;

  logic [1:0] g_a, g_b, rv, rid, m_en, m_we, bsy;
  logic [7:0] rrd [2];
  logic [2:0] m_addr [2];
  logic [7:0] m_wd [2];
  logic [7:0] m_rd [2];
  logic [7:0] crc_o [2];

  logic [7:0] mem [2][8];
  int         k_rd [2];
  logic [7:0] ref_mem [2][8];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_W(8), .ADDR_W(3), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req_a(req_a && !tgt), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(g_a[0]),
    .req_b(req_b && !tgt), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(g_b[0]),
    .resp_valid(rv[0]), .resp_id(rid[0]), .resp_rdata(rrd[0]),
    .mem_en(m_en[0]), .mem_we(m_we[0]), .mem_addr(m_addr[0]),
    .mem_wdata(m_wd[0]), .mem_rdata(m_rd[0]),
    .busy(bsy[0])
`ifdef MEM_ACCESS_CRC_EN
    , .resp_crc(crc_o[0])
`endif
  );

  mem_access_ctrl #(.DATA_W(8), .ADDR_W(3), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .req_a(req_a && tgt), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(g_a[1]),
    .req_b(req_b && tgt), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(g_b[1]),
    .resp_valid(rv[1]), .resp_id(rid[1]), .resp_rdata(rrd[1]),
    .mem_en(m_en[1]), .mem_we(m_we[1]), .mem_addr(m_addr[1]),
    .mem_wdata(m_wd[1]), .mem_rdata(m_rd[1]),
    .busy(bsy[1])
`ifdef MEM_ACCESS_CRC_EN
    , .resp_crc(crc_o[1])
`endif
  );

`ifndef MEM_ACCESS_CRC_EN
  assign crc_o[0] = 8'h00;
  assign crc_o[1] = 8'h00;
`endif

  // Memory: read data is valid only in the cycle MEM_LAT after the strobe
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_en[i] && m_we[i]) mem[i][m_addr[i]] <= m_wd[i];
      if (m_en[i] && !m_we[i]) k_rd[i] <= 1;
      else if (k_rd[i] != 0 && k_rd[i] < 4) k_rd[i] <= k_rd[i] + 1;
      else k_rd[i] <= 0;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      m_rd[i] = (k_rd[i] == (i == 1 ? 3 : 1)) ? mem[i][m_addr[i]] : 8'hEE;
    end
  end

  logic       o_ga, o_gb, o_rv, o_rid, o_en, o_we, o_busy;
  logic [2:0] o_addr;
  logic [7:0] o_wd, o_rd, o_crc;
  always_comb begin
    o_ga   = g_a[tgt];
    o_gb   = g_b[tgt];
    o_rv   = rv[tgt];
    o_rid  = rid[tgt];
    o_en   = m_en[tgt];
    o_we   = m_we[tgt];
    o_busy = bsy[tgt];
    o_addr = m_addr[tgt];
    o_wd   = m_wd[tgt];
    o_rd   = rrd[tgt];
    o_crc  = crc_o[tgt];
  end

  // CRC as remainder of (data * x^8) mod 0x107
  function automatic logic [7:0] ref_crc(input logic [7:0] d);
    logic [15:0] v;
    v = {d, 8'h00};
    for (int b = 15; b >= 8; b--)
      if (v[b]) v = v ^ (16'h0107 << (b - 8));
    return v[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {o_ga, o_gb, o_rv, o_rid, o_en, o_we, o_busy,
              o_addr, o_wd, o_rd}, 32'h0);
    chk({tag, "_crc"}, o_crc, 8'h00);
  endtask

  task automatic access(input logic t, input logic id, input logic we,
                        input logic [2:0] a, input logic [7:0] d,
                        input logic pulse_a);
    int dly;
    logic [7:0] exp_rd;
    dly = we ? 1 : (1 + (t ? 3 : 1));
    exp_rd = we ? 8'h00 : ref_mem[t][a];
    tgt = t;
    if (id) begin
      req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d;
    end else begin
      req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d;
    end
    @(negedge clk);
    chk("gnt_a", o_ga, {31'd0, !id});
    chk("gnt_b", o_gb, {31'd0, id});
    chk("mem_en", o_en, 1);
    chk("mem_we", o_we, {31'd0, we});
    chk("mem_addr", o_addr, {29'd0, a});
    if (we) chk("mem_wdata", o_wd, {24'd0, d});
    chk("busy", o_busy, 1);
    if (id) req_b = 1'b0; else req_a = 1'b0;
    for (int k = 1; k <= dly; k++) begin
      if (pulse_a && k == 1) req_a = 1'b1;
      if (pulse_a && k == 2) req_a = 1'b0;
      @(negedge clk);
      chk("mem_en_off", o_en, 0);
      chk("gnt_off", {o_ga, o_gb}, 0);
      chk("resp_valid", o_rv, {31'd0, k == dly});
    end
    if (pulse_a) req_a = 1'b0;
    chk("resp_id", o_rid, {31'd0, id});
    chk("resp_rdata", o_rd, {24'd0, exp_rd});
`ifdef MEM_ACCESS_CRC_EN
    chk("resp_crc", o_crc, {24'd0, we ? 8'h00 : ref_crc(exp_rd)});
`endif
    if (we) ref_mem[t][a] = d;
    @(negedge clk);
    chk("idle_after", {o_busy, o_rv}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ng, nen, lastc;
    logic [7:0] wa, wb;
    logic [2:0] aa, ab;
    rst = 1'b1; tgt = 1'b0;
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset_lat1");
    tgt = 1'b1; #1;
    chk_zero("reset_lat3");
    rst = 1'b0;
    @(negedge clk);

    access(0, 0, 1, 3'd3, 8'h5A, 0);
    access(0, 1, 0, 3'd3, 8'h00, 0);
    access(1, 0, 1, 3'd3, 8'h5A, 0);
    access(1, 1, 0, 3'd3, 8'h00, 0);

    for (int t = 0; t < 2; t++)
      for (int r = 0; r < 8; r++)
        access(t[0], 1'($urandom_range(0, 1)), 1, r[2:0],
               8'($urandom), 0);

    for (int n = 0; n < 40; n++)
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             8'($urandom), 0);

    // A pulses while busy; it must never be granted
    access(1, 1, 0, 3'd5, 8'h00, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("pulse_no_gnt", {o_ga, o_busy}, 0);
    end
    access(1, 1, 1, 3'd6, 8'hC3, 0);

    // Continuous ties after reset: A first, then strict alternation
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tgt = 1'b0;
    aa = 3'd1; ab = 3'd2;
    wa = 8'($urandom); wb = 8'($urandom);
    req_a = 1; we_a = 1; addr_a = aa; wdata_a = wa;
    req_b = 1; we_b = 1; addr_b = ab; wdata_b = wb;
    ng = 0; nen = 0; lastc = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (o_en) nen++;
      chk("tie_excl", {31'd0, o_ga & o_gb}, 0);
      if (o_ga || o_gb) begin
        chk("tie_order", {o_ga, o_gb}, (ng % 2) ? 2'b01 : 2'b10);
        if (ng > 0) chk("tie_gap", c - lastc, 3);
        lastc = c;
        ng++;
        if (ng == 6) begin req_a = 0; req_b = 0; end
      end
    end
    req_a = 0; req_b = 0;
    chk("tie_grants", ng, 6);
    chk("tie_mem_en", nen, 6);
    ref_mem[0][aa] = wa;
    ref_mem[0][ab] = wb;

    // Reset during WAIT of a read by A
    tgt = 1'b1;
    req_a = 1; we_a = 0; addr_a = 3'd3;
    @(negedge clk);
    chk("rstw_gnt_a", o_ga, 1);
    req_a = 0;
    @(negedge clk);
    chk("rstw_in_wait", {o_busy, o_rv}, 2'b10);
    rst = 1'b1;
    #1;
    chk_zero("rstw_async");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rstw_no_resp", {o_rv, o_en}, 0);
    end
    req_a = 1; we_a = 1; addr_a = 3'd4; wdata_a = 8'h3C;
    req_b = 1; we_b = 1; addr_b = 3'd7; wdata_b = 8'h99;
    @(negedge clk);
    chk("rstw_tie", {o_ga, o_gb}, 2'b10);
    req_a = 0; req_b = 0;
    repeat (2) @(negedge clk);
    chk("rstw_done", o_busy, 0);
    ref_mem[1][4] = 8'h3C;

    // Directed CRC data points
    access(0, 0, 1, 3'd0, 8'h01, 0);
    access(0, 1, 0, 3'd0, 8'h00, 0);
    access(1, 0, 1, 3'd1, 8'h00, 0);
    access(1, 0, 0, 3'd1, 8'h00, 0);
`ifdef MEM_ACCESS_CRC_EN
    access(0, 1, 0, 3'd0, 8'h00, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
